// File: rtl/generador_pkg.sv
// generador_pkg: shared state type and sizing helper for the edge generator
package generador_pkg;

    typedef enum logic [1:0] {BAJO, BAJO_ESPERA, ALTO, ALTO_ESPERA} estado_gen_t;

    // Hold counter width; never narrower than one bit
    function automatic int ancho_cnt(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m > 1 ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/generador_flancos.sv
// generador_flancos: turns rise/fall requests into a registered level with minimum high/low times
// Early requests wait one deep until the hold expires; simultaneous rise+fall is rejected.
module generador_flancos
    import generador_pkg::*;
#(
    parameter int MIN_ALTO = 4,
    parameter int MIN_BAJO = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_subida,
    input  logic req_bajada,
    output logic signal_out,
    output logic ocupado,
    output logic descartado
);

    localparam int CW = ancho_cnt(MIN_ALTO, MIN_BAJO);
    localparam logic [CW-1:0] CARGA_ALTO = CW'(MIN_ALTO - 1);
    localparam logic [CW-1:0] CARGA_BAJO = CW'(MIN_BAJO - 1);

    estado_gen_t   estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          signal_q, ocupado_q, descartado_q;
    logic          alto, espera, conflicto, opuesto, mismo, pend_eff, mover;

    assign alto      = estado_q inside {ALTO, ALTO_ESPERA};
    assign espera    = estado_q inside {BAJO_ESPERA, ALTO_ESPERA};
    assign conflicto = req_subida && req_bajada;
    assign opuesto   = alto ? req_bajada : req_subida;
    assign mismo     = alto ? req_subida : req_bajada;
    // A request back to the current level cancels a pending one
    assign pend_eff  = pend_q ? !mismo : opuesto;
    assign mover     = !conflicto && (espera ? (cnt_q == '0 && pend_eff) : opuesto);

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        if (mover) begin
            estado_d = alto ? BAJO_ESPERA : ALTO_ESPERA;
            cnt_d    = alto ? CARGA_BAJO : CARGA_ALTO;
            pend_d   = 1'b0;
        end else if (espera && !conflicto) begin
            estado_d = cnt_q == '0 ? (alto ? ALTO : BAJO) : estado_q;
            cnt_d    = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            pend_d   = cnt_q != '0 && pend_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q     <= BAJO;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            signal_q     <= 1'b0;
            ocupado_q    <= 1'b0;
            descartado_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            signal_q     <= estado_d inside {ALTO, ALTO_ESPERA};
            ocupado_q    <= (estado_d inside {BAJO_ESPERA, ALTO_ESPERA}) || pend_d;
            descartado_q <= conflicto;
        end
    end

    assign signal_out = signal_q;
    assign ocupado    = ocupado_q;
    assign descartado = descartado_q;

endmodule

// File: tb/tb_generador_flancos.sv
// tb_generador_flancos: directed scenarios checked against a timeline model every cycle plus literal spot checks
module tb_generador_flancos;

    localparam int MIN_ALTO = 4;
    localparam int MIN_BAJO = 2;

    logic clk, rst, req_subida, req_bajada;
    logic signal_out, ocupado, descartado;

    generador_flancos #(.MIN_ALTO(MIN_ALTO), .MIN_BAJO(MIN_BAJO)) dut (
        .clk(clk), .rst(rst), .req_subida(req_subida), .req_bajada(req_bajada),
        .signal_out(signal_out), .ocupado(ocupado), .descartado(descartado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk = 0;

    // Model: current level, cycle its last change became visible, pending flag
    bit m_lvl = 0;
    bit m_pend = 0;
    int m_s = -100;
    int m_c = 0;
    bit e_sig = 0, e_oc = 0, e_de = 0;

    logic obs_sig [0:31];
    logic obs_oc  [0:31];
    logic obs_de  [0:31];

    task automatic check(input string n, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%b want=%b at %0t", n, a, e, $time);
        end
    endtask

    task automatic modelo(input bit s, input bit b, input bit r);
        int  h;
        bit  hold, can, opp, same, p;
        h    = m_lvl ? MIN_ALTO : MIN_BAJO;
        hold = m_c < m_s + h;
        can  = m_c + 1 >= m_s + h;
        e_de = 0;
        if (r) begin
            m_lvl = 0; m_pend = 0; m_s = -100;
        end else if (s && b) begin
            e_de = 1;
            if (hold) m_s++;
        end else begin
            opp  = m_lvl ? b : s;
            same = m_lvl ? s : b;
            p    = hold && (m_pend ? !same : opp);
            if (!hold ? opp : (can && p)) begin
                m_lvl = !m_lvl; m_s = m_c + 1; m_pend = 0;
            end else begin
                m_pend = can ? 0 : p;
            end
        end
        m_c++;
        h     = m_lvl ? MIN_ALTO : MIN_BAJO;
        e_sig = m_lvl;
        e_oc  = (m_c < m_s + h) || m_pend;
    endtask

    always @(negedge clk) if (chk) begin
        check("model_signal_out", signal_out, e_sig);
        check("model_ocupado", ocupado, e_oc);
        check("model_descartado", descartado, e_de);
    end

    task automatic ciclo(input bit s, input bit b, input bit r, input int k);
        req_subida = s; req_bajada = b; rst = r;
        @(negedge clk);
        if (k >= 0) begin
            obs_sig[k] = signal_out; obs_oc[k] = ocupado; obs_de[k] = descartado;
        end
        @(posedge clk);
        modelo(s, b, r);
        #1;
    endtask

    task automatic escenario(input bit [19:0] sv, input bit [19:0] bv, input bit [19:0] rv, input int n);
        ciclo(0, 0, 1, -1);
        for (int k = 0; k < n; k++) ciclo(sv[k], bv[k], rv[k], k);
    endtask

    initial begin
        req_subida = 0; req_bajada = 0; rst = 1;
        @(posedge clk); #1;
        // Reset with random requests
        ciclo(1'($urandom), 1'($urandom), 1, 0);
        chk = 1;
        ciclo(1'($urandom), 1'($urandom), 1, 1);
        ciclo(0, 0, 0, 2);
        ciclo(0, 0, 0, 3);
        for (int k = 1; k <= 3; k++) begin
            check("rst_sig", obs_sig[k], 0);
            check("rst_oc", obs_oc[k], 0);
            check("rst_de", obs_de[k], 0);
        end
        // Single rise
        escenario(20'h00020, 20'h0, 20'h0, 12);
        check("rise_sig5", obs_sig[5], 0);
        for (int k = 6; k <= 9; k++) begin
            check("rise_sig", obs_sig[k], 1);
            check("rise_oc", obs_oc[k], 1);
        end
        check("rise_sig10", obs_sig[10], 1);
        check("rise_oc10", obs_oc[10], 0);
        // Early fall queued
        escenario(20'h00020, 20'h00080, 20'h0, 14);
        check("queue_sig9", obs_sig[9], 1);
        check("queue_sig10", obs_sig[10], 0);
        check("queue_oc8", obs_oc[8], 1);
        check("queue_oc11", obs_oc[11], 1);
        check("queue_oc12", obs_oc[12], 0);
        check("queue_sig13", obs_sig[13], 0);
        // Cancel
        escenario(20'h000A0, 20'h00040, 20'h0, 16);
        for (int k = 6; k < 16; k++) check("cancel_sig", obs_sig[k], 1);
        for (int k = 0; k < 16; k++) check("cancel_de", obs_de[k], 0);
        check("cancel_oc10", obs_oc[10], 0);
        // Conflict
        escenario(20'h00008, 20'h00008, 20'h0, 8);
        for (int k = 0; k < 8; k++) begin
            check("conf_sig", obs_sig[k], 0);
            check("conf_de", obs_de[k], k == 4);
        end
        // Reset mid-hold with pending
        escenario(20'h00020, 20'h00040, 20'h00100, 14);
        check("rmid_sig7", obs_sig[7], 1);
        check("rmid_oc8", obs_oc[8], 1);
        for (int k = 9; k < 14; k++) begin
            check("rmid_sig", obs_sig[k], 0);
            check("rmid_oc", obs_oc[k], 0);
        end
        // Fall requested in last hold cycle, conflict inside low hold, then rise
        escenario(20'h00182, 20'h000A0, 20'h0, 14);
        check("mix_sig5", obs_sig[5], 1);
        check("mix_sig6", obs_sig[6], 0);
        check("mix_de8", obs_de[8], 1);
        check("mix_sig9", obs_sig[9], 1);
        chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
